// File: rtl/contrast_stretcher_if.sv
// ---------------------------------------------------------------------------
// contrast_stretcher_if
// Pixel stream bundle for the contrast stretcher: one YCbCr pixel per beat
// with frame markers.
//   valid           pixel qualifier
//   sof / eof       first / last pixel of a frame (only meaningful with valid)
//   y_data          luma component
//   cb_data/cr_data chroma components
// The master modport drives the stream and the slave modport receives it.
// ---------------------------------------------------------------------------
interface contrast_stretcher_if #(
  parameter int DATA_W = 8
);
  logic              valid;
  logic              sof;
  logic              eof;
  logic [DATA_W-1:0] y_data;
  logic [DATA_W-1:0] cb_data;
  logic [DATA_W-1:0] cr_data;

  modport master (output valid, sof, eof, y_data, cb_data, cr_data);
  modport slave  (input  valid, sof, eof, y_data, cb_data, cr_data);
endinterface

// File: rtl/contrast_stretcher.sv
// ---------------------------------------------------------------------------
// contrast_stretcher
// Linear luma stretch Y' = sat((Y - offset) * gain) with delay-matched Cb/Cr.
// Gain and offset come from bypass (unity), manual (software) or auto mode.
// In auto mode the per-frame Y min/max is measured and a serial restoring
// divider turns the range into a gain that takes effect from the next frame.
//
// Ports
//   clk, rst      pixel clock, synchronous active-high reset
//   mode_i        0/3 bypass, 1 manual, 2 auto (sampled at sof)
//   man_gain_i    manual gain, unsigned, FRAC_W fractional bits
//   man_offset_i  manual black level
//   pix_i         input pixel stream (slave)
//   pix_o         output pixel stream, 3 cycles behind pix_i (master)
//   gain_o        gain in force for the current frame
//   busy_o        divider is iterating
// ---------------------------------------------------------------------------
module contrast_stretcher #(
  parameter int DATA_W = 8,
  parameter int FRAC_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               mode_i,
  input  logic [DATA_W+FRAC_W-1:0] man_gain_i,
  input  logic [DATA_W-1:0]        man_offset_i,
  contrast_stretcher_if.slave      pix_i,
  contrast_stretcher_if.master     pix_o,
  output logic [DATA_W+FRAC_W-1:0] gain_o,
  output logic                     busy_o
);

  localparam int GAIN_W = DATA_W + FRAC_W;
  localparam int PROD_W = DATA_W + GAIN_W;
  localparam int CNT_W  = $clog2(GAIN_W);

  localparam logic [GAIN_W-1:0] UNITY_GAIN = GAIN_W'(1) << FRAC_W;
  localparam logic [GAIN_W-1:0] DIV_NUM    = {{DATA_W{1'b1}}, {FRAC_W{1'b0}}};
  localparam logic [CNT_W-1:0]  LAST_STEP  = CNT_W'(GAIN_W - 1);

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_RUN,
    DIV_PEND
  } divState_e;

  // Accepted frame markers
  logic sofAcc;
  logic eofAcc;

  // Frame configuration
  logic [GAIN_W-1:0] cfgGain_q;
  logic [DATA_W-1:0] cfgOff_q;
  logic [GAIN_W-1:0] selGain;
  logic [DATA_W-1:0] selOff;
  logic [GAIN_W-1:0] curGain;
  logic [DATA_W-1:0] curOff;
  logic [GAIN_W-1:0] autoGain_q;
  logic [DATA_W-1:0] autoOff_q;

  // Datapath stages
  logic              s1Valid_q, s1Sof_q, s1Eof_q;
  logic [DATA_W-1:0] s1Diff_q, s1Cb_q, s1Cr_q;
  logic [GAIN_W-1:0] s1Gain_q;
  logic [DATA_W-1:0] s1Diff_d;
  logic              s2Valid_q, s2Sof_q, s2Eof_q;
  logic [PROD_W-1:0] s2Prod_q;
  logic [DATA_W-1:0] s2Cb_q, s2Cr_q;
  logic [PROD_W-1:0] prodShift;
  logic [DATA_W-1:0] s3Y_d;
  logic              s3Valid_q, s3Sof_q, s3Eof_q;
  logic [DATA_W-1:0] s3Y_q, s3Cb_q, s3Cr_q;

  // Statistics
  logic              inFrame_q;
  logic [DATA_W-1:0] min_q, max_q;
  logic [DATA_W-1:0] min_d, max_d;
  logic              statUpd;
  logic              trigger;
  logic [DATA_W-1:0] trigRange;

  // Divider
  divState_e         state_q, state_d;
  logic              loadFlat, loadDiv, divStep, divDone, takePend;
  logic [DATA_W-1:0] divisor_q, rem_q, divMin_q;
  logic [GAIN_W-1:0] quot_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W:0]   trial;
  logic              fits;
  logic [DATA_W-1:0] remNext;
  logic [GAIN_W-1:0] quotNext;
  logic [GAIN_W-1:0] resGain_q;
  logic [DATA_W-1:0] resOff_q;

  assign sofAcc = pix_i.valid & pix_i.sof;
  assign eofAcc = pix_i.valid & pix_i.eof;

  // Pick the configuration a new frame would start with. In auto mode a
  // result waiting in PEND is taken directly so the frame that starts in the
  // same cycle already uses it; the sof pixel itself must also see the new
  // values, so the current gain/offset bypass the frame registers on sof.
  always_comb begin
    selGain = UNITY_GAIN;
    selOff  = '0;
    case (mode_i)
      2'd1: begin
        selGain = man_gain_i;
        selOff  = man_offset_i;
      end
      2'd2: begin
        selGain = (state_q == DIV_PEND) ? resGain_q : autoGain_q;
        selOff  = (state_q == DIV_PEND) ? resOff_q  : autoOff_q;
      end
      default: begin
        selGain = UNITY_GAIN;
        selOff  = '0;
      end
    endcase
    curGain = sofAcc ? selGain : cfgGain_q;
    curOff  = sofAcc ? selOff  : cfgOff_q;
  end

  // Frame configuration and auto result registers. The gain/offset pair is
  // frozen at sof for the whole frame; a pending auto result is promoted at
  // sof as a matched pair so gain and black level never mix across frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfgGain_q  <= UNITY_GAIN;
      cfgOff_q   <= '0;
      autoGain_q <= UNITY_GAIN;
      autoOff_q  <= '0;
    end else begin
      if (sofAcc) begin
        cfgGain_q <= selGain;
        cfgOff_q  <= selOff;
      end
      if (takePend) begin
        autoGain_q <= resGain_q;
        autoOff_q  <= resOff_q;
      end
    end
  end

  assign gain_o = cfgGain_q;

  // Stage 1 subtracts the black level and clamps at zero. Each pixel carries
  // its own gain forward so a frame boundary inside the pipeline is harmless.
  always_comb begin
    s1Diff_d = (pix_i.y_data >= curOff) ? (pix_i.y_data - curOff) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1Valid_q <= 1'b0;
      s1Sof_q   <= 1'b0;
      s1Eof_q   <= 1'b0;
      s1Diff_q  <= '0;
      s1Gain_q  <= '0;
      s1Cb_q    <= '0;
      s1Cr_q    <= '0;
    end else begin
      s1Valid_q <= pix_i.valid;
      s1Sof_q   <= sofAcc;
      s1Eof_q   <= eofAcc;
      if (pix_i.valid) begin
        s1Diff_q <= s1Diff_d;
        s1Gain_q <= curGain;
        s1Cb_q   <= pix_i.cb_data;
        s1Cr_q   <= pix_i.cr_data;
      end
    end
  end

  // Stage 2 forms the full-width product so nothing is lost before rounding
  // down and saturating in stage 3.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2Valid_q <= 1'b0;
      s2Sof_q   <= 1'b0;
      s2Eof_q   <= 1'b0;
      s2Prod_q  <= '0;
      s2Cb_q    <= '0;
      s2Cr_q    <= '0;
    end else begin
      s2Valid_q <= s1Valid_q;
      s2Sof_q   <= s1Sof_q;
      s2Eof_q   <= s1Eof_q;
      if (s1Valid_q) begin
        s2Prod_q <= PROD_W'(s1Diff_q) * PROD_W'(s1Gain_q);
        s2Cb_q   <= s1Cb_q;
        s2Cr_q   <= s1Cr_q;
      end
    end
  end

  // Stage 3 drops the fraction bits and saturates anything above full scale.
  always_comb begin
    prodShift = s2Prod_q >> FRAC_W;
    s3Y_d     = (|prodShift[PROD_W-1:DATA_W]) ? {DATA_W{1'b1}} : prodShift[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s3Valid_q <= 1'b0;
      s3Sof_q   <= 1'b0;
      s3Eof_q   <= 1'b0;
      s3Y_q     <= '0;
      s3Cb_q    <= '0;
      s3Cr_q    <= '0;
    end else begin
      s3Valid_q <= s2Valid_q;
      s3Sof_q   <= s2Sof_q;
      s3Eof_q   <= s2Eof_q;
      if (s2Valid_q) begin
        s3Y_q  <= s3Y_d;
        s3Cb_q <= s2Cb_q;
        s3Cr_q <= s2Cr_q;
      end
    end
  end

  assign pix_o.valid   = s3Valid_q;
  assign pix_o.sof     = s3Sof_q;
  assign pix_o.eof     = s3Eof_q;
  assign pix_o.y_data  = s3Y_q;
  assign pix_o.cb_data = s3Cb_q;
  assign pix_o.cr_data = s3Cr_q;

  // Frame statistics. Only pixels inside an sof..eof window count, so junk
  // seen before the first sof after reset never reaches the divider. The
  // eof pixel is folded in combinationally before the divider is triggered.
  always_comb begin
    statUpd   = pix_i.valid & (pix_i.sof | inFrame_q);
    trigger   = statUpd & pix_i.eof;
    min_d     = (pix_i.sof || pix_i.y_data < min_q) ? pix_i.y_data : min_q;
    max_d     = (pix_i.sof || pix_i.y_data > max_q) ? pix_i.y_data : max_q;
    trigRange = max_d - min_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inFrame_q <= 1'b0;
      min_q     <= '0;
      max_q     <= '0;
    end else if (statUpd) begin
      inFrame_q <= ~pix_i.eof;
      min_q     <= min_d;
      max_q     <= max_d;
    end
  end

  // Divider state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DIV_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Divider next state. A fresh eof always wins and restarts from new
  // statistics; a flat frame skips the division and is pending at once.
  always_comb begin
    state_d = state_q;
    if (trigger) begin
      state_d = (trigRange == '0) ? DIV_PEND : DIV_RUN;
    end else begin
      case (state_q)
        DIV_RUN:  if (cnt_q == LAST_STEP) state_d = DIV_PEND;
        DIV_PEND: if (sofAcc) state_d = DIV_IDLE;
        default:  state_d = state_q;
      endcase
    end
  end

  // Divider control outputs decoded from the current state and trigger.
  always_comb begin
    busy_o   = (state_q == DIV_RUN);
    loadFlat = trigger & (trigRange == '0);
    loadDiv  = trigger & (trigRange != '0);
    divStep  = ~trigger & (state_q == DIV_RUN);
    divDone  = divStep & (cnt_q == LAST_STEP);
    takePend = sofAcc & (state_q == DIV_PEND);
  end

  // One restoring step: shift the next numerator bit into the remainder and
  // subtract the range when it fits. The quotient bits replace the numerator
  // bits in the same register as they shift out of the top.
  always_comb begin
    trial    = {rem_q, quot_q[GAIN_W-1]};
    fits     = (trial >= {1'b0, divisor_q});
    remNext  = fits ? DATA_W'(trial - {1'b0, divisor_q}) : trial[DATA_W-1:0];
    quotNext = {quot_q[GAIN_W-2:0], fits};
  end

  // Divider datapath and the pending (gain, black level) result.
  always_ff @(posedge clk) begin
    if (rst) begin
      divisor_q <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      cnt_q     <= '0;
      divMin_q  <= '0;
      resGain_q <= UNITY_GAIN;
      resOff_q  <= '0;
    end else begin
      if (loadFlat) begin
        resGain_q <= UNITY_GAIN;
        resOff_q  <= min_d;
      end
      if (loadDiv) begin
        divisor_q <= trigRange;
        rem_q     <= '0;
        quot_q    <= DIV_NUM;
        cnt_q     <= '0;
        divMin_q  <= min_d;
      end else if (divStep) begin
        rem_q  <= remNext;
        quot_q <= quotNext;
        cnt_q  <= cnt_q + CNT_W'(1);
        if (divDone) begin
          resGain_q <= quotNext;
          resOff_q  <= divMin_q;
        end
      end
    end
  end

endmodule
